// File: rtl/bcd_countdown.sv
// bcd_countdown: packed-BCD game countdown (in: clk, reset sync active-low, init_time, game_state, sec_timer, strike, pause; out: value, running, warning, expired pulse)
module bcd_countdown #(
    parameter int DIGITS = 3,
    parameter logic [4*DIGITS-1:0] PENALTY = 'h010,
    parameter logic [4*DIGITS-1:0] WARN = 'h030,
    parameter logic [7:0] ACTIVE_ST = 8'h10,
    parameter logic [7:0] WIN_ST = 8'h20,
    parameter logic [7:0] LOSE_ST = 8'h30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] init_time,
    input  logic [7:0]          game_state,
    input  logic                sec_timer,
    input  logic                strike,
    input  logic                pause,
    output logic [4*DIGITS-1:0] value,
    output logic                running,
    output logic                warning,
    output logic                expired
);
    localparam int W = 4 * DIGITS;
    typedef enum logic [2:0] {IDLE, RUN, PAUSED, HOLD, EXPIRED} state_t;
    state_t state, state_n;
    logic [W-1:0] value_n, init_s, run_sub, pau_sub;
    logic expired_n, game_end, game_other;

    function automatic logic [W-1:0] sanitise(input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i+:4] = (b[4*i+:4] > 4'd9) ? 4'd9 : b[4*i+:4];
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [4:0] d;
        logic borrow;
        borrow = 1'b0;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i+:4]} - {1'b0, b[4*i+:4]} - {4'd0, borrow};
            borrow = d[4];
            r[4*i+:4] = borrow ? d[3:0] + 4'd10 : d[3:0];
        end
        return (a < b) ? '0 : r;
    endfunction

    assign init_s = sanitise(init_time);
    assign game_end = game_state == WIN_ST || game_state == LOSE_ST;
    assign game_other = !game_end && game_state != ACTIVE_ST;
    assign run_sub = bcd_sub(bcd_sub(value, {{(W-1){1'b0}}, sec_timer}), strike ? PENALTY : '0);
    assign pau_sub = bcd_sub(value, strike ? PENALTY : '0);
    assign running = state == RUN;

    always_comb begin
        state_n = state;
        value_n = value;
        expired_n = 1'b0;
        case (state)
            IDLE: begin
                value_n = init_s;
                state_n = game_state == ACTIVE_ST ? RUN : IDLE;
            end
            RUN, PAUSED: begin
                if (game_end) state_n = HOLD;
                else if (game_other) state_n = IDLE;
                else if (value == '0) state_n = EXPIRED;
                else begin
                    value_n = state == RUN ? run_sub : pau_sub;
                    expired_n = value_n == '0;
                    state_n = expired_n ? EXPIRED : pause ? PAUSED : RUN;
                end
            end
            default: state_n = (game_end || game_state == ACTIVE_ST) ? state : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            value <= init_s;
            warning <= 1'b0;
            expired <= 1'b0;
        end else begin
            state <= state_n;
            value <= value_n;
            expired <= expired_n;
            warning <= (state_n == RUN || state_n == PAUSED) && value_n != '0 && value_n < WARN;
        end
    end
endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: directed vector table, pause sequence and randomized run against a decimal reference model
module tb_bcd_countdown;
    localparam logic [7:0] ACT = 8'h10, WIN = 8'h20, LOSE = 8'h30;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAU = 2, S_HOLD = 3, S_EXP = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [11:0] init_time = '0;
    logic [7:0] game_state = '0;
    logic sec_timer = 1'b0, strike = 1'b0, pause = 1'b0;
    logic [11:0] value;
    logic running, warning, expired;

    bcd_countdown dut (
        .clk(clk), .reset(reset), .init_time(init_time), .game_state(game_state),
        .sec_timer(sec_timer), .strike(strike), .pause(pause),
        .value(value), .running(running), .warning(warning), .expired(expired)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int m_st = S_IDLE, m_val = 0;
    logic m_warn = 1'b0, m_exp = 1'b0;

    typedef struct {
        logic r; logic [7:0] gs; logic tk, sk, pz; logic [11:0] ini;
        logic [11:0] val; logic run, warn, exp;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic int san(input logic [11:0] b);
        int r = 0;
        for (int i = 2; i >= 0; i--) begin
            logic [3:0] d = b[4*i+:4];
            r = r * 10 + ((d > 9) ? 9 : int'(d));
        end
        return r;
    endfunction

    function automatic logic [11:0] i2b(input int v);
        logic [11:0] b;
        for (int i = 0; i < 3; i++) begin
            b[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    task automatic model(input logic r, input logic [7:0] g, input logic t, input logic s, input logic p, input logic [11:0] ini);
        bit fin = (g == WIN) || (g == LOSE);
        bit other = !fin && g != ACT;
        int nv;
        m_exp = 1'b0;
        if (!r) begin
            m_st = S_IDLE;
            m_val = san(ini);
        end else if (m_st == S_IDLE) begin
            m_val = san(ini);
            if (g == ACT) m_st = S_RUN;
        end else if (m_st == S_RUN || m_st == S_PAU) begin
            if (fin) m_st = S_HOLD;
            else if (other) m_st = S_IDLE;
            else if (m_val == 0) m_st = S_EXP;
            else begin
                nv = m_val - ((t && m_st == S_RUN) ? 1 : 0) - (s ? 10 : 0);
                if (nv <= 0) begin
                    m_val = 0;
                    m_st = S_EXP;
                    m_exp = 1'b1;
                end else begin
                    m_val = nv;
                    m_st = p ? S_PAU : S_RUN;
                end
            end
        end else if (other) m_st = S_IDLE;
        m_warn = r && (m_st == S_RUN || m_st == S_PAU) && m_val != 0 && m_val < 30;
    endtask

    task automatic step(input logic r, input logic [7:0] g, input logic t, input logic s, input logic p, input logic [11:0] ini);
        @(negedge clk);
        reset = r; game_state = g; sec_timer = t; strike = s; pause = p; init_time = ini;
        @(posedge clk);
        model(r, g, t, s, p, ini);
        #1;
    endtask

    task automatic add(input logic r, input logic [7:0] g, input logic t, input logic s, input logic p,
                       input logic [11:0] ini, input logic [11:0] val, input logic run, input logic w, input logic e);
        vt.push_back('{r, g, t, s, p, ini, val, run, w, e});
    endtask

    task automatic chk4(input string tag, input logic [11:0] v, input logic run, input logic w, input logic e);
        chk({tag, " value"}, value, v);
        chk({tag, " running"}, {11'd0, running}, {11'd0, run});
        chk({tag, " warning"}, {11'd0, warning}, {11'd0, w});
        chk({tag, " expired"}, {11'd0, expired}, {11'd0, e});
    endtask

    initial begin
        add(0, 8'h00, 0, 0, 0, 12'h200, 12'h200, 0, 0, 0);
        add(1, ACT,   0, 0, 0, 12'h200, 12'h200, 1, 0, 0);
        add(1, ACT,   1, 0, 0, 12'h200, 12'h199, 1, 0, 0);
        add(1, ACT,   1, 0, 0, 12'h200, 12'h198, 1, 0, 0);
        add(1, ACT,   1, 0, 0, 12'h200, 12'h197, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 12'h003, 12'h003, 0, 0, 0);
        add(1, ACT,   0, 0, 0, 12'h003, 12'h003, 1, 1, 0);
        add(1, ACT,   1, 0, 0, 12'h003, 12'h002, 1, 1, 0);
        add(1, ACT,   1, 0, 0, 12'h003, 12'h001, 1, 1, 0);
        add(1, ACT,   1, 0, 0, 12'h003, 12'h000, 0, 0, 1);
        add(1, ACT,   1, 0, 0, 12'h003, 12'h000, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 12'h003, 12'h000, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 12'h003, 12'h003, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 12'h015, 12'h015, 0, 0, 0);
        add(1, ACT,   0, 0, 0, 12'h015, 12'h015, 1, 1, 0);
        add(1, ACT,   1, 1, 0, 12'h015, 12'h004, 1, 1, 0);
        add(0, 8'h00, 0, 0, 0, 12'h008, 12'h008, 0, 0, 0);
        add(1, ACT,   0, 0, 0, 12'h008, 12'h008, 1, 1, 0);
        add(1, ACT,   0, 1, 0, 12'h008, 12'h000, 0, 0, 1);
        add(1, 8'h00, 0, 0, 0, 12'h008, 12'h000, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 12'h031, 12'h031, 0, 0, 0);
        add(1, ACT,   0, 0, 0, 12'h031, 12'h031, 1, 0, 0);
        add(1, ACT,   1, 0, 0, 12'h031, 12'h030, 1, 0, 0);
        add(1, ACT,   1, 0, 0, 12'h031, 12'h029, 1, 1, 0);
        add(0, 8'h00, 0, 0, 0, 12'h123, 12'h123, 0, 0, 0);
        add(1, ACT,   0, 0, 0, 12'h123, 12'h123, 1, 0, 0);
        add(1, WIN,   1, 0, 0, 12'h123, 12'h123, 0, 0, 0);
        add(1, WIN,   1, 0, 0, 12'h123, 12'h123, 0, 0, 0);
        add(1, LOSE,  1, 1, 0, 12'h123, 12'h123, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 12'h456, 12'h123, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 12'h456, 12'h456, 0, 0, 0);
        add(1, ACT,   0, 0, 0, 12'h456, 12'h456, 1, 0, 0);
        add(1, ACT,   1, 0, 0, 12'h456, 12'h455, 1, 0, 0);
        add(0, ACT,   1, 1, 0, 12'h777, 12'h777, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 12'hA5F, 12'h959, 0, 0, 0);
        add(1, ACT,   0, 0, 0, 12'hA5F, 12'h959, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0);
        add(1, ACT,   0, 0, 0, 12'h000, 12'h000, 1, 0, 0);
        add(1, ACT,   1, 0, 0, 12'h000, 12'h000, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0);
        foreach (vt[i]) begin
            step(vt[i].r, vt[i].gs, vt[i].tk, vt[i].sk, vt[i].pz, vt[i].ini);
            chk4($sformatf("vec%0d", i), vt[i].val, vt[i].run, vt[i].warn, vt[i].exp);
        end

        step(0, 8'h00, 0, 0, 0, 12'h100);
        step(1, ACT, 0, 0, 0, 12'h100);
        step(1, ACT, 1, 0, 0, 12'h100);
        chk4("pause pre", 12'h099, 1, 0, 0);
        step(1, ACT, 0, 0, 1, 12'h100);
        chk4("pause enter", 12'h099, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, ACT, 1, 0, 1, 12'h100);
            chk4($sformatf("pause tick%0d", i), 12'h099, 0, 0, 0);
        end
        step(1, ACT, 0, 1, 1, 12'h100);
        chk4("pause strike", 12'h089, 0, 0, 0);
        step(1, ACT, 0, 0, 0, 12'h100);
        chk4("resume", 12'h089, 1, 0, 0);
        step(1, ACT, 1, 0, 0, 12'h100);
        chk4("resume tick", 12'h088, 1, 0, 0);

        for (int n = 0; n < 4000; n++) begin
            logic [7:0] g;
            case ($urandom_range(0, 11))
                0: g = 8'h00;
                1: g = WIN;
                2: g = LOSE;
                3: g = 8'h45;
                default: g = ACT;
            endcase
            step($urandom_range(0, 59) != 0, g, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 6) == 0, 12'($urandom_range(0, 12'h0FF)));
            chk4($sformatf("rnd%0d", n), i2b(m_val), m_st == S_RUN, m_warn, m_exp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
